// File: rtl/fifo_pkg.sv
// Shared FIFO definitions used by both the reader and the writer side:
// default widths and the modular pointer-difference helper.
package fifo_pkg;

  localparam int unsigned DATA_W_DEF = 8;
  localparam int unsigned ADDR_W_DEF = 4;

  // (a - b) modulo 2^ptr_w; pointers are zero-extended to 32 bits by the caller.
  function automatic logic [31:0] ptr_diff(input logic [31:0] a, input logic [31:0] b,
                                           input int unsigned ptr_w);
    logic [31:0] mask;
    mask = (ptr_w >= 32) ? '1 : ((32'd1 << ptr_w) - 32'd1);
    return (a - b) & mask;
  endfunction

endpackage

// File: rtl/fifo_rd_skid.sv
// Two-entry head/skid output buffer for the FIFO reader. Incoming words go to
// head when it is free after this cycle's pop, otherwise to skid. Skid moves
// into head in the same cycle head is popped, so word order is preserved.
module fifo_rd_skid
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic              skid_valid
);

  logic [DATA_W-1:0] head_d, head_q, skid_d, skid_q;
  logic              head_v_d, head_v_q, skid_v_d, skid_v_q;
  logic              pop;

  // Next-state for head/skid; the reader never sends a word when both are busy.
  always_comb begin
    head_d   = head_q;
    head_v_d = head_v_q;
    skid_d   = skid_q;
    skid_v_d = skid_v_q;
    pop      = head_v_q && out_ready;
    if (pop) begin
      if (skid_v_q) begin
        head_d   = skid_q;
        head_v_d = 1'b1;
        skid_v_d = in_valid;
        if (in_valid) skid_d = in_data;
      end else begin
        head_v_d = in_valid;
        if (in_valid) head_d = in_data;
      end
    end else if (in_valid) begin
      if (!head_v_q) begin
        head_d   = in_data;
        head_v_d = 1'b1;
      end else begin
        skid_d   = in_data;
        skid_v_d = 1'b1;
      end
    end
  end

  // Buffer registers, cleared asynchronously so dout reads zero during reset.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      head_q   <= '0;
      head_v_q <= 1'b0;
      skid_q   <= '0;
      skid_v_q <= 1'b0;
    end else begin
      head_q   <= head_d;
      head_v_q <= head_v_d;
      skid_q   <= skid_d;
      skid_v_q <= skid_v_d;
    end
  end

  assign out_valid  = head_v_q;
  assign out_data   = head_q;
  assign skid_valid = skid_v_q;

endmodule

// File: rtl/fifo_reader.sv
// FIFO read side with first-word-fall-through output. Issues storage reads
// while the head/skid buffer plus the in-flight read leaves room, and returns
// its pointer to the writer side.
// Optional feature: define FIFO_RD_ALMOST_EMPTY_EN to add AE_LEVEL and the
// almost_empty output.
module fifo_reader
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF
`ifdef FIFO_RD_ALMOST_EMPTY_EN
  ,
  parameter int unsigned AE_LEVEL = 2
`endif
) (
  input  logic              clk,
  input  logic              clr,
  input  logic [ADDR_W:0]   wr_ptr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [ADDR_W:0]   rd_ptr,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  output logic [DATA_W-1:0] dout,
  input  logic              dout_ready,
  output logic              dout_valid
`ifdef FIFO_RD_ALMOST_EMPTY_EN
  ,
  output logic              almost_empty
`endif
);

  localparam int unsigned PTR_W = ADDR_W + 1;

  logic [PTR_W-1:0] rd_ptr_d, rd_ptr_q;
  logic             inflight_q;
  logic             head_v, skid_v, pop;
  logic [1:0]       occ, occ_after;

  assign empty   = (wr_ptr == rd_ptr_q);
  assign count   = PTR_W'(ptr_diff(32'(wr_ptr), 32'(rd_ptr_q), PTR_W));
  assign rd_ptr  = rd_ptr_q;
  assign rd_addr = rd_ptr_q[ADDR_W-1:0];

  // Read request: room for one more word once this cycle's pop is accounted for.
  always_comb begin
    pop       = head_v && dout_ready;
    occ       = {1'b0, head_v} + {1'b0, skid_v} + {1'b0, inflight_q};
    occ_after = occ - {1'b0, pop};
    rd_en     = !clr && !empty && (occ_after < 2'd2);
    rd_ptr_d  = rd_ptr_q + PTR_W'(rd_en);
  end

  // Pointer and in-flight flag; clr drops any outstanding read.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      rd_ptr_q   <= '0;
      inflight_q <= 1'b0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      inflight_q <= rd_en;
    end
  end

  fifo_rd_skid #(
    .DATA_W (DATA_W)
  ) u_skid (
    .clk        (clk),
    .clr        (clr),
    .in_valid   (inflight_q),
    .in_data    (mem_rdata),
    .out_valid  (head_v),
    .out_data   (dout),
    .out_ready  (dout_ready),
    .skid_valid (skid_v)
  );

  assign dout_valid = head_v;

`ifdef FIFO_RD_ALMOST_EMPTY_EN
  assign almost_empty = clr || (32'(count) <= AE_LEVEL);
`endif

endmodule

// File: tb/tb_fifo_reader.sv
// Directed bench for fifo_reader: a writer/storage model drives wr_ptr and
// mem_rdata; expected values are hand-computed for each step.
module tb_fifo_reader;

  localparam int unsigned DW = 8;
  localparam int unsigned AW = 4;

  logic          clk = 1'b0;
  logic          clr;
  logic [AW:0]   wr_ptr;
  logic [DW-1:0] mem_rdata = '0;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [AW:0]   rd_ptr;
  logic          empty;
  logic [AW:0]   count;
  logic [DW-1:0] dout;
  logic          dout_ready;
  logic          dout_valid;
`ifdef FIFO_RD_ALMOST_EMPTY_EN
  logic          almost_empty;
`endif

  fifo_reader #(
    .DATA_W (DW),
    .ADDR_W (AW)
`ifdef FIFO_RD_ALMOST_EMPTY_EN
    ,
    .AE_LEVEL (2)
`endif
  ) dut (
    .clk        (clk),
    .clr        (clr),
    .wr_ptr     (wr_ptr),
    .mem_rdata  (mem_rdata),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .rd_ptr     (rd_ptr),
    .empty      (empty),
    .count      (count),
    .dout       (dout),
    .dout_ready (dout_ready),
    .dout_valid (dout_valid)
`ifdef FIFO_RD_ALMOST_EMPTY_EN
    ,
    .almost_empty (almost_empty)
`endif
  );

  always #5 clk = ~clk;

  // Storage model: read data valid one cycle after rd_en.
  logic [DW-1:0] mem [16];
  always @(posedge clk) if (rd_en) mem_rdata <= mem[rd_addr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Consumer / activity monitor, sampled mid-cycle.
  logic [DW-1:0] got[$];
  int            got_cyc[$];
  int            rd_cnt = 0;
  bit            wrapped = 1'b0;
  logic [AW:0]   prev_rd_ptr = '0;
  always @(negedge clk) begin
    if (dout_valid && dout_ready) begin
      got.push_back(dout);
      got_cyc.push_back(cyc);
    end
    if (rd_en) rd_cnt++;
    if (prev_rd_ptr == 5'd31 && rd_ptr == 5'd0) wrapped = 1'b1;
    prev_rd_ptr = rd_ptr;
  end

  int checks = 0;
  int passed = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic write_burst(input int n, input logic [DW-1:0] base);
    for (int i = 0; i < n; i++) begin
      mem[wr_ptr[AW-1:0]] = base + DW'(i);
      wr_ptr = wr_ptr + 1'b1;
    end
  endtask

  initial begin
    int wcyc;
    int rd0;
    for (int i = 0; i < 16; i++) mem[i] = '0;
    clr        = 1'b1;
    wr_ptr     = '0;
    dout_ready = 1'b0;

    // Reset state
    tick(2);
    check("rst_rd_ptr", 32'(rd_ptr), 32'd0);
    check("rst_rd_en", 32'(rd_en), 32'd0);
    check("rst_dout_valid", 32'(dout_valid), 32'd0);
    check("rst_dout", 32'(dout), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_count", 32'(count), 32'd0);
`ifdef FIFO_RD_ALMOST_EMPTY_EN
    check("rst_almost_empty", 32'(almost_empty), 32'd1);
`endif
    clr = 1'b0;
    tick(1);

    // Write while empty: no read in the writer's cycle, read the next cycle
    check("wr_empty_rd_en_n", 32'(rd_en), 32'd0);
    tick(1);
    write_burst(1, 8'hA5);
    #1;
    check("wr_empty_rd_en_n1", 32'(rd_en), 32'd1);
    check("wr_empty_rd_addr", 32'(rd_addr), 32'd0);
    tick(1);
    check("lat_rd_en_idle", 32'(rd_en), 32'd0);
    check("lat_valid_early", 32'(dout_valid), 32'd0);
    check("lat_rd_ptr", 32'(rd_ptr), 32'd1);
    tick(1);
    check("lat_valid", 32'(dout_valid), 32'd1);
    check("lat_dout", 32'(dout), 32'hA5);
    check("lat_count", 32'(count), 32'd0);
    got.delete();
    got_cyc.delete();
    dout_ready = 1'b1;
    tick(1);
    dout_ready = 1'b0;
    #1;
    check("pop_valid_low", 32'(dout_valid), 32'd0);
    check("pop_got_n", 32'(got.size()), 32'd1);
    check("pop_got_0", 32'(got[0]), 32'hA5);

    // Streaming 16 words, full FIFO, one word per cycle
    got.delete();
    got_cyc.delete();
    dout_ready = 1'b1;
    tick(1);
    write_burst(16, 8'h01);
    wcyc = cyc;
    #1;
    check("stream_count_full", 32'(count), 32'd16);
    check("stream_rd_en", 32'(rd_en), 32'd1);
    tick(22);
    check("stream_n", 32'(got.size()), 32'd16);
    for (int i = 0; i < 16; i++)
      check($sformatf("stream[%0d]", i), 32'(got[i]), 32'(i + 1));
    check("stream_latency", 32'(got_cyc[0] - wcyc), 32'd2);
    check("stream_rate", 32'(got_cyc[15] - got_cyc[0]), 32'd15);
    check("stream_empty", 32'(empty), 32'd1);
    check("stream_count", 32'(count), 32'd0);
    check("stream_rd_ptr", 32'(rd_ptr), 32'd17);

    // Backpressure: only two words pulled, dout frozen
    dout_ready = 1'b0;
    got.delete();
    got_cyc.delete();
    tick(1);
    rd0 = rd_cnt;
    write_burst(5, 8'h21);
    tick(10);
    check("bp_reads", 32'(rd_cnt - rd0), 32'd2);
    check("bp_count", 32'(count), 32'd3);
    check("bp_rd_ptr", 32'(rd_ptr), 32'd19);
    check("bp_valid", 32'(dout_valid), 32'd1);
    check("bp_dout", 32'(dout), 32'h21);
    dout_ready = 1'b1;
    tick(10);
    check("bp_n", 32'(got.size()), 32'd5);
    for (int i = 0; i < 5; i++)
      check($sformatf("bp[%0d]", i), 32'(got[i]), 32'(8'h21 + i));
    check("bp_empty", 32'(empty), 32'd1);

    // Reset mid-stream with 3 words stored and a read in flight
    dout_ready = 1'b0;
    got.delete();
    got_cyc.delete();
    tick(1);
    write_burst(3, 8'h31);
    tick(1);
    #2;
    clr    = 1'b1;
    wr_ptr = '0;
    #1;
    check("clr_rd_ptr", 32'(rd_ptr), 32'd0);
    check("clr_rd_en", 32'(rd_en), 32'd0);
    check("clr_valid", 32'(dout_valid), 32'd0);
    check("clr_dout", 32'(dout), 32'd0);
    tick(2);
    clr        = 1'b0;
    dout_ready = 1'b1;
    rd0        = rd_cnt;
    tick(6);
    check("clr_no_stale", 32'(got.size()), 32'd0);
    check("clr_no_read", 32'(rd_cnt - rd0), 32'd0);
    check("clr_valid_after", 32'(dout_valid), 32'd0);

    // Wrap: 40 words in bursts of 7, rd_ptr passes 31 -> 0
    got.delete();
    got_cyc.delete();
    wrapped = 1'b0;
    for (int b = 0; b < 6; b++) begin
      int n;
      n = (b == 5) ? 5 : 7;
      tick(1);
      write_burst(n, 8'h40 + DW'(7 * b));
      #1;
      check($sformatf("wrap_count_b%0d", b), 32'(count), 32'(n));
      tick(11);
    end
    check("wrap_seen", 32'(wrapped), 32'd1);
    check("wrap_n", 32'(got.size()), 32'd40);
    for (int i = 0; i < 40; i++)
      check($sformatf("wrap[%0d]", i), 32'(got[i]), 32'(8'h40 + i));
    check("wrap_count", 32'(count), 32'd0);
    check("wrap_empty", 32'(empty), 32'd1);
    check("wrap_rd_ptr", 32'(rd_ptr), 32'd8);

    // Count 3 -> 2 (almost_empty threshold when enabled)
    dout_ready = 1'b0;
    tick(1);
    write_burst(3, 8'h91);
    #1;
    check("ae_count3", 32'(count), 32'd3);
`ifdef FIFO_RD_ALMOST_EMPTY_EN
    check("ae_low", 32'(almost_empty), 32'd0);
`endif
    tick(1);
    check("ae_count2", 32'(count), 32'd2);
`ifdef FIFO_RD_ALMOST_EMPTY_EN
    check("ae_high", 32'(almost_empty), 32'd1);
`endif
    dout_ready = 1'b1;
    tick(8);
    check("final_empty", 32'(empty), 32'd1);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
